// File: rtl/iob_axi_burst_master_pkg.sv
// Shared AXI constants and burst-master state encoding.
// Imported by every AXI block in this slice so encodings stay consistent.
package iob_axi_burst_master_pkg;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WDATA = 3'd2,
    S_WRESP = 3'd3,
    S_RADDR = 3'd4,
    S_RDATA = 3'd5
  } state_t;

endpackage

// File: rtl/iob_axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one command becomes one AW/W/B or AR/R burst.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module iob_axi_burst_master
  import iob_axi_burst_master_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int ID_W   = 8,
  parameter int LEN_W  = 8,
  parameter int AXI_ID = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_strb_i,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  output logic [DATA_W-1:0]   rd_data_o,
  output logic                rd_last_o,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic                done_o,
  output logic                err_o,
  output logic                busy_o,
  output logic [2:0]          dbg_state_o,
  output logic [ID_W-1:0]     axi_awid_o,
  output logic [ADDR_W-1:0]   axi_awaddr_o,
  output logic [LEN_W-1:0]    axi_awlen_o,
  output logic [2:0]          axi_awsize_o,
  output logic [1:0]          axi_awburst_o,
  output logic [1:0]          axi_awlock_o,
  output logic [3:0]          axi_awcache_o,
  output logic [2:0]          axi_awprot_o,
  output logic [3:0]          axi_awqos_o,
  output logic                axi_awvalid_o,
  input  logic                axi_awready_i,
  output logic [DATA_W-1:0]   axi_wdata_o,
  output logic [DATA_W/8-1:0] axi_wstrb_o,
  output logic                axi_wlast_o,
  output logic                axi_wvalid_o,
  input  logic                axi_wready_i,
  input  logic [ID_W-1:0]     axi_bid_i,
  input  logic [1:0]          axi_bresp_i,
  input  logic                axi_bvalid_i,
  output logic                axi_bready_o,
  output logic [ID_W-1:0]     axi_arid_o,
  output logic [ADDR_W-1:0]   axi_araddr_o,
  output logic [LEN_W-1:0]    axi_arlen_o,
  output logic [2:0]          axi_arsize_o,
  output logic [1:0]          axi_arburst_o,
  output logic [1:0]          axi_arlock_o,
  output logic [3:0]          axi_arcache_o,
  output logic [2:0]          axi_arprot_o,
  output logic [3:0]          axi_arqos_o,
  output logic                axi_arvalid_o,
  input  logic                axi_arready_i,
  input  logic [ID_W-1:0]     axi_rid_i,
  input  logic [DATA_W-1:0]   axi_rdata_i,
  input  logic [1:0]          axi_rresp_i,
  input  logic                axi_rlast_i,
  input  logic                axi_rvalid_i,
  output logic                axi_rready_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int EW    = LEN_W + 14;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic                r_done;
  logic                r_err;
  logic [EW-1:0]       w_span_end;
  logic                w_cross;
  logic                w_last_beat;
  logic                w_w_hs;
  logic                w_r_hs;
  logic                w_unused;

  // End of the burst within its 4KB page; anything past 4096 would cross the boundary.
  assign w_span_end  = EW'(cmd_addr_i[11:0]) + (EW'(cmd_len_i) + EW'(1)) * EW'(BYTES);
  assign w_cross     = w_span_end > EW'(4096);
  assign w_last_beat = (r_cnt == r_len);
  assign w_w_hs      = (r_state == S_WDATA) && wr_valid_i && axi_wready_i;
  assign w_r_hs      = (r_state == S_RDATA) && axi_rvalid_i && rd_ready_i;
  assign w_unused    = ^axi_rid_i;

  assign axi_awid_o    = ID_W'(AXI_ID);
  assign axi_awaddr_o  = r_addr;
  assign axi_awlen_o   = r_len;
  assign axi_awsize_o  = 3'($clog2(BYTES));
  assign axi_awburst_o = BURST_INCR;
  assign axi_awlock_o  = 2'b00;
  assign axi_awcache_o = CACHE_DEFAULT;
  assign axi_awprot_o  = 3'b000;
  assign axi_awqos_o   = 4'b0000;
  assign axi_arid_o    = ID_W'(AXI_ID);
  assign axi_araddr_o  = r_addr;
  assign axi_arlen_o   = r_len;
  assign axi_arsize_o  = 3'($clog2(BYTES));
  assign axi_arburst_o = BURST_INCR;
  assign axi_arlock_o  = 2'b00;
  assign axi_arcache_o = CACHE_DEFAULT;
  assign axi_arprot_o  = 3'b000;
  assign axi_arqos_o   = 4'b0000;

  assign axi_wdata_o = wr_data_i;
  assign axi_wstrb_o = wr_strb_i;
  assign rd_data_o   = axi_rdata_i;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_addr <= cmd_addr_i;
            r_len  <= cmd_len_i;
            r_cnt  <= '0;
            r_err  <= w_cross;
            r_done <= w_cross;
          end
        end
        S_WDATA: begin
          if (w_w_hs) r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
        end
        S_WRESP: begin
          if (axi_bvalid_i) begin
            r_err  <= (axi_bresp_i != RESP_OKAY) || (axi_bid_i != ID_W'(AXI_ID));
            r_done <= 1'b1;
          end
        end
        S_RDATA: begin
          if (w_r_hs) begin
            // Error stays sticky for the whole read once any beat misbehaves.
            if ((axi_rresp_i != RESP_OKAY) || (axi_rlast_i != w_last_beat)) r_err <= 1'b1;
            r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
            if (w_last_beat) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    cmd_ready_o   = 1'b0;
    axi_awvalid_o = 1'b0;
    axi_wvalid_o  = 1'b0;
    wr_ready_o    = 1'b0;
    axi_wlast_o   = 1'b0;
    axi_bready_o  = 1'b0;
    axi_arvalid_o = 1'b0;
    axi_rready_o  = 1'b0;
    rd_valid_o    = 1'b0;
    rd_last_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i && !w_cross) w_state_nxt = cmd_we_i ? S_WADDR : S_RADDR;
      end
      S_WADDR: begin
        axi_awvalid_o = 1'b1;
        if (axi_awready_i) w_state_nxt = S_WDATA;
      end
      S_WDATA: begin
        axi_wvalid_o = wr_valid_i;
        wr_ready_o   = axi_wready_i;
        axi_wlast_o  = w_last_beat;
        if (w_w_hs && w_last_beat) w_state_nxt = S_WRESP;
      end
      S_WRESP: begin
        axi_bready_o = 1'b1;
        if (axi_bvalid_i) w_state_nxt = S_IDLE;
      end
      S_RADDR: begin
        axi_arvalid_o = 1'b1;
        if (axi_arready_i) w_state_nxt = S_RDATA;
      end
      S_RDATA: begin
        rd_valid_o   = axi_rvalid_i;
        axi_rready_o = rd_ready_i;
        rd_last_o    = w_last_beat;
        if (w_r_hs && w_last_beat) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/iob_axi_burst_master.md
IOB_AXI_BURST_MASTER -- requirements
Module: iob_axi_burst_master

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, AXI data width (power of 2, >=8); ADDR_W, 16, byte address width; ID_W, 8, AXI ID width; LEN_W, 8, burst length field width; AXI_ID, 0, constant ID driven on awid_o/arid_o.
REQ-002 clk_i  in  1  clock; all logic rising-edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid_i in 1, cmd_ready_o out 1, cmd_we_i in 1 (1=write), cmd_addr_i in ADDR_W (byte addr, DATA_W/8-aligned), cmd_len_i in LEN_W (beats-1): command port.
REQ-005 wr_data_i in DATA_W, wr_strb_i in DATA_W/8, wr_valid_i in 1, wr_ready_o out 1: write data stream.
REQ-006 rd_data_o out DATA_W, rd_last_o out 1, rd_valid_o out 1, rd_ready_i in 1: read data stream.
REQ-007 done_o out 1 (one-cycle pulse, command complete), err_o out 1 (error status of last command), busy_o out 1 (FSM not IDLE).
REQ-008 AXI4 AW channel out: axi_awid_o ID_W, awaddr_o ADDR_W, awlen_o LEN_W, awsize_o 3, awburst_o 2, awlock_o 2, awcache_o 4, awprot_o 3, awqos_o 4, awvalid_o 1; in: awready_i 1.
REQ-009 AXI4 W channel out: axi_wdata_o DATA_W, wstrb_o DATA_W/8, wlast_o 1, wvalid_o 1; in: wready_i 1.
REQ-010 AXI4 B channel in: axi_bid_i ID_W, bresp_i 2, bvalid_i 1; out: bready_o 1.
REQ-011 AXI4 AR channel: same fields/widths as AW with ar prefix.
REQ-012 AXI4 R channel in: axi_rid_i ID_W, rdata_i DATA_W, rresp_i 2, rlast_i 1, rvalid_i 1; out: rready_o 1.

Function
REQ-013 FSM states SHALL be IDLE, WADDR, WDATA, WRESP, RADDR, RDATA; one command in flight; cmd_ready_o = (state==IDLE).
REQ-014 Command accept (cmd_valid_i & cmd_ready_o) SHALL latch addr/len/we and clear err_o; next state WADDR (we=1) or RADDR (we=0).
REQ-015 4KB check at accept: if addr[11:0] + (len+1)*DATA_W/8 > 4096, no AXI traffic; next cycle done_o=1, err_o=1, state stays IDLE.
REQ-016 Constant AXI fields: size=log2(DATA_W/8), burst=2'b01 INCR, lock=0, cache=4'b0011, prot=0, qos=0, id=AXI_ID; awaddr/awlen and araddr/arlen from latched command.
REQ-017 WADDR: awvalid_o registered high, held stable until awready_i; handshake -> WDATA, awvalid_o low next cycle.
REQ-018 WDATA: wvalid_o=wr_valid_i, wr_ready_o=wready_i, wdata/wstrb pass-through combinationally; beat counter increments per W handshake; wlast_o=(count==len); last handshake -> WRESP.
REQ-019 WRESP: bready_o=1; on bvalid_i: err_o=(bresp_i!=0)|(bid_i!=AXI_ID), done_o pulse next cycle, -> IDLE.
REQ-020 RADDR: arvalid_o registered, held until arready_i; -> RDATA.
REQ-021 RDATA: rd_valid_o=rvalid_i, rready_o=rd_ready_i, rd_data_o=rdata_i, rd_last_o=(count==len); each handshake with rresp_i!=0 or rlast_i!=(count==len) sets err_o (sticky for command); handshake at count==len -> done_o pulse, IDLE.
REQ-022 Back-pressure on any channel SHALL stall indefinitely without data loss or duplicate beats; len=0 SHALL produce a single beat with last=1.
REQ-023 Beat counter LEN_W bits; len=2**LEN_W-1 SHALL not overflow before final beat.

Reset
REQ-024 rst_i SHALL force IDLE immediately; awvalid_o, wvalid_o-gating, arvalid_o, bready_o, rready_o, done_o, err_o, busy_o, counter = 0; cmd_ready_o=1 after release.
REQ-025 Reset mid-burst SHALL abandon transfer; the AXI responder is reset by the same rst_i.

Structure
REQ-026 AXI constants (BURST_INCR, RESP_OKAY, CACHE default) and state encodings SHALL live in a shared include header used by all AXI blocks.
REQ-027 Single module; no sub-module.

Verification (bench pairs DUT with an AXI4 RAM responder model)
REQ-028 Write addr 0x0040 len 3, data 0x11..0x44, strb 0xF -> 4 W beats, wlast on 4th, done_o=1, err_o=0; memory words 0x10-0x13 updated.
REQ-029 Read addr 0x0040 len 3 with rd_ready_i toggling 1/0 -> rd_data 0x11,0x22,0x33,0x44 in order, rd_last_o only on 4th, done_o once.
REQ-030 Write addr 0x0FF8 len 3 (DATA_W=32) -> no awvalid_o, done_o=1, err_o=1 one cycle after accept.
REQ-031 Responder returns bresp=2'b10 -> err_o=1 with done_o; next accepted command clears err_o.
REQ-032 awready_i held low 10 cycles -> awvalid_o/awaddr_o stable throughout; len=0 write -> single beat, wlast_o=1.
REQ-033 rst_i asserted during RDATA beat 2 of len 7 -> all valids/readys low same cycle, cmd_ready_o=1 after release.
